// File: rtl/ps2_keyevent_decoder_if.sv
// Byte-strobe input and key-event output bundle of the PS/2 key event decoder.
// The master side is the upstream byte receiver plus event consumer; the slave side is the decoder.
interface ps2_keyevent_decoder_if;
   logic       iTrig;
   logic [7:0] iData;
   logic       oTrig;
   logic [7:0] oCode;
   logic       oExt;
   logic       oMake;
   logic [7:0] oAscii;
   logic       oShift;
   logic       oCtrl;
   logic       oCaps;
   logic       oAbort;

   modport master (
      output iTrig, iData,
      input  oTrig, oCode, oExt, oMake, oAscii, oShift, oCtrl, oCaps, oAbort
   );

   modport slave (
      input  iTrig, iData,
      output oTrig, oCode, oExt, oMake, oAscii, oShift, oCtrl, oCaps, oAbort
   );
endinterface

// File: rtl/ps2_keyevent_decoder.sv
// Folds Set 2 scancode byte sequences (E0/F0/E1 prefixes) into single key events.
// Also tracks the Shift/Ctrl/Caps Lock modifiers and maps a subset of keys to ASCII.
module ps2_keyevent_decoder #(
   parameter int TIMEOUT_CYC = 2500000,
   parameter int CNT_W       = 22
) (
   input logic                  CLOCK,
   input logic                  RESET,
   ps2_keyevent_decoder_if.slave bus
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] EXT    = 3'd1;
   localparam logic [2:0] BRK    = 3'd2;
   localparam logic [2:0] EXTBRK = 3'd3;
   localparam logic [2:0] SKIP   = 3'd4;

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       skip_q, skip_d;
   logic             trig_q, abort_q, abort_d;
   logic [7:0]       code_q, ascii_q;
   logic             ext_q, make_q;
   logic             shiftL_q, shiftL_d, shiftR_q, shiftR_d;
   logic             ctrlL_q, ctrlL_d, ctrlR_q, ctrlR_d;
   logic             caps_q, caps_d, capsHeld_q, capsHeld_d;
   logic             evt, evtExt, evtMake;
   logic [7:0]       evtCode;

   function automatic logic [7:0] asciiOf(input logic [7:0] code, input logic ext,
                                          input logic shift, input logic caps);
      logic [4:0] idx;
      logic [3:0] dig;
      logic       isLetter, isDigit;
      logic [7:0] res;
      idx      = '0;
      dig      = '0;
      isLetter = 1'b1;
      isDigit  = 1'b1;
      res      = 8'h00;
      case (code)
         8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
         8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
         8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
         8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
         8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
         8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
         8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
         default: isLetter = 1'b0;
      endcase
      case (code)
         8'h45: dig = 4'd0;  8'h16: dig = 4'd1;  8'h1E: dig = 4'd2;  8'h26: dig = 4'd3;
         8'h25: dig = 4'd4;  8'h2E: dig = 4'd5;  8'h36: dig = 4'd6;  8'h3D: dig = 4'd7;
         8'h3E: dig = 4'd8;  8'h46: dig = 4'd9;
         default: isDigit = 1'b0;
      endcase
      if (code == 8'h5A) begin
         res = 8'h0D;
      end else if (!ext) begin
         if (isLetter) begin
            res = ((shift ^ caps) ? 8'h41 : 8'h61) + {3'b000, idx};
         end else if (isDigit) begin
            res = shift ? 8'h00 : (8'h30 + {4'b0000, dig});
         end else begin
            case (code)
               8'h29:   res = 8'h20;
               8'h66:   res = 8'h08;
               8'h76:   res = 8'h1B;
               default: res = 8'h00;
            endcase
         end
      end
      return res;
   endfunction

   // Sequence FSM plus timeout: a byte strobe always clears the timer and beats the timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      skip_d  = skip_q;
      abort_d = 1'b0;
      evt     = 1'b0;
      evtCode = bus.iData;
      evtExt  = 1'b0;
      evtMake = 1'b1;
      if (bus.iTrig) begin
         cnt_d = '0;
         case (state_q)
            IDLE: begin
               case (bus.iData)
                  8'hE0: state_d = EXT;
                  8'hF0: state_d = BRK;
                  8'hE1: begin
                     state_d = SKIP;
                     skip_d  = 3'd7;
                  end
                  8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                  default: evt = 1'b1;
               endcase
            end
            EXT: begin
               if (bus.iData == 8'hF0) begin
                  state_d = EXTBRK;
               end else if (bus.iData == 8'h12) begin
                  state_d = IDLE;
               end else if (bus.iData != 8'hE0) begin
                  evt     = 1'b1;
                  evtExt  = 1'b1;
                  state_d = IDLE;
               end
            end
            BRK: begin
               evt     = 1'b1;
               evtMake = 1'b0;
               state_d = IDLE;
            end
            EXTBRK: begin
               state_d = IDLE;
               if (bus.iData != 8'h12) begin
                  evt     = 1'b1;
                  evtExt  = 1'b1;
                  evtMake = 1'b0;
               end
            end
            SKIP: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) begin
                  evt     = 1'b1;
                  evtCode = 8'h77;
                  evtExt  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (cnt_q == TIMEOUT_VAL) begin
            state_d = IDLE;
            cnt_d   = '0;
            abort_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Modifier tracking; caps_held suppresses toggling on typematic repeats of Caps Lock.
   always_comb begin
      shiftL_d   = shiftL_q;
      shiftR_d   = shiftR_q;
      ctrlL_d    = ctrlL_q;
      ctrlR_d    = ctrlR_q;
      caps_d     = caps_q;
      capsHeld_d = capsHeld_q;
      if (evt) begin
         if (!evtExt && evtCode == 8'h12) shiftL_d = evtMake;
         if (!evtExt && evtCode == 8'h59) shiftR_d = evtMake;
         if (evtCode == 8'h14) begin
            if (evtExt) ctrlR_d = evtMake;
            else        ctrlL_d = evtMake;
         end
         if (evtCode == 8'h58) begin
            if (evtMake && !capsHeld_q) caps_d = ~caps_q;
            capsHeld_d = evtMake;
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         skip_q     <= '0;
         trig_q     <= 1'b0;
         abort_q    <= 1'b0;
         code_q     <= '0;
         ext_q      <= 1'b0;
         make_q     <= 1'b0;
         ascii_q    <= '0;
         shiftL_q   <= 1'b0;
         shiftR_q   <= 1'b0;
         ctrlL_q    <= 1'b0;
         ctrlR_q    <= 1'b0;
         caps_q     <= 1'b0;
         capsHeld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         skip_q     <= skip_d;
         trig_q     <= evt;
         abort_q    <= abort_d;
         shiftL_q   <= shiftL_d;
         shiftR_q   <= shiftR_d;
         ctrlL_q    <= ctrlL_d;
         ctrlR_q    <= ctrlR_d;
         caps_q     <= caps_d;
         capsHeld_q <= capsHeld_d;
         if (evt) begin
            code_q  <= evtCode;
            ext_q   <= evtExt;
            make_q  <= evtMake;
            ascii_q <= asciiOf(evtCode, evtExt, shiftL_q | shiftR_q, caps_q);
         end
      end
   end

   assign bus.oTrig  = trig_q;
   assign bus.oCode  = code_q;
   assign bus.oExt   = ext_q;
   assign bus.oMake  = make_q;
   assign bus.oAscii = ascii_q;
   assign bus.oShift = shiftL_q | shiftR_q;
   assign bus.oCtrl  = ctrlL_q | ctrlR_q;
   assign bus.oCaps  = caps_q;
   assign bus.oAbort = abort_q;

endmodule

// File: tb/tb_ps2_keyevent_decoder.sv
// Drives directed and random scancode sequences into the decoder and compares every
// output after each byte with a prefix-list model of key events, modifiers and ASCII.
module tb_ps2_keyevent_decoder;

   localparam int TIMEOUT = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   ps2_keyevent_decoder_if bus ();

   ps2_keyevent_decoder #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(22)) dut (
      .CLOCK (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: bytes of the sequence in progress plus held outputs.
   logic [7:0] pend[$];
   logic [7:0] eCode, eAscii;
   logic       eExt, eMake;
   logic       shL, shR, ctL, ctR, caps, capsHeld;

   logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
   logic [7:0] digitCodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
   logic [7:0] keyPool [18] = '{8'h1C, 8'h32, 8'h1A, 8'h21, 8'h45, 8'h16, 8'h46, 8'h29, 8'h66,
                                8'h76, 8'h5A, 8'h12, 8'h59, 8'h14, 8'h58, 8'h75, 8'h7C, 8'h11};
   logic [7:0] ignPool [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

   function automatic logic [7:0] modelAscii(input logic [7:0] code, input logic ext);
      logic shift;
      shift = shL | shR;
      if (code == 8'h5A) return 8'h0D;
      if (ext) return 8'h00;
      for (int i = 0; i < 26; i++)
         if (letterCodes[i] == code) return 8'((shift != caps) ? 65 + i : 97 + i);
      for (int i = 0; i < 10; i++)
         if (digitCodes[i] == code) return shift ? 8'h00 : 8'(48 + i);
      if (code == 8'h29) return 8'h20;
      if (code == 8'h66) return 8'h08;
      if (code == 8'h76) return 8'h1B;
      return 8'h00;
   endfunction

   function automatic bit isIgnored(input logic [7:0] b);
      foreach (ignPool[i]) if (ignPool[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic modelClear();
      pend.delete();
      eCode = 0; eAscii = 0; eExt = 0; eMake = 0;
      shL = 0; shR = 0; ctL = 0; ctR = 0; caps = 0; capsHeld = 0;
   endtask

   task automatic modelByte(input logic [7:0] b, output bit evt);
      logic [7:0] code;
      logic       ext, make;
      int         n;
      evt = 0; code = b; ext = 0; make = 1;
      pend.push_back(b);
      n = pend.size();
      if (pend[0] == 8'hE1) begin
         if (n == 8) begin
            evt = 1; code = 8'h77; ext = 1; make = 1;
            pend.delete();
         end
      end else if (n == 1 && isIgnored(b)) begin
         pend.delete();
      end else if (n == 1 && (b == 8'hE0 || b == 8'hF0)) begin
      end else if (n == 2 && pend[0] == 8'hE0 && b == 8'hF0) begin
      end else if (n == 2 && pend[0] == 8'hE0 && b == 8'hE0) begin
         void'(pend.pop_back());
      end else if (pend[0] == 8'hE0 && b == 8'h12) begin
         pend.delete();
      end else begin
         evt  = 1;
         ext  = (pend[0] == 8'hE0);
         make = !(pend[0] == 8'hF0 || (n > 2 && pend[1] == 8'hF0));
         pend.delete();
      end
      if (evt) begin
         eCode = code; eExt = ext; eMake = make;
         eAscii = modelAscii(code, ext);
         if (!ext && code == 8'h12) shL = make;
         if (!ext && code == 8'h59) shR = make;
         if (code == 8'h14) begin
            if (ext) ctR = make;
            else     ctL = make;
         end
         if (code == 8'h58) begin
            if (make && !capsHeld) caps = !caps;
            capsHeld = make;
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input bit expTrig);
      checkOutput("oTrig", bus.oTrig, expTrig);
      checkOutput("oCode", bus.oCode, eCode);
      checkOutput("oExt", bus.oExt, eExt);
      checkOutput("oMake", bus.oMake, eMake);
      checkOutput("oAscii", bus.oAscii, eAscii);
      checkOutput("oShift", bus.oShift, shL | shR);
      checkOutput("oCtrl", bus.oCtrl, ctL | ctR);
      checkOutput("oCaps", bus.oCaps, caps);
      checkOutput("oAbort", bus.oAbort, 1'b0);
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      bit evt;
      @(negedge clk);
      checkOutput("trigPulseEnd", bus.oTrig, 1'b0);
      bus.iTrig = 1'b1;
      bus.iData = b;
      @(negedge clk);
      bus.iTrig = 1'b0;
      bus.iData = $urandom_range(0, 255);
      modelByte(b, evt);
      checkAll(evt);
   endtask

   task automatic applySeq(input logic [7:0] s[$]);
      foreach (s[i]) applyStimulus(s[i]);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      bus.iTrig = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      modelClear();
      checkAll(1'b0);
   endtask

   initial begin
      int abortCount;
      int firstAbort;
      bit trigSeen;
      int op;
      logic [7:0] k;

      bus.iTrig = 1'b0;
      bus.iData = 8'h00;
      modelClear();
      doReset();

      applySeq('{8'h1C, 8'hF0, 8'h1C});
      applySeq('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C});
      applySeq('{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C, 8'h58, 8'hF0, 8'h58, 8'h1C});
      applySeq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
      applySeq('{8'hE0, 8'h12, 8'hE0, 8'h7C, 8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12});
      applySeq('{8'h14, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hF0, 8'h14});
      applySeq('{8'hAA, 8'hFA, 8'h59, 8'h45, 8'h29, 8'hF0, 8'h59, 8'h45, 8'hE0, 8'h5A});
      applySeq('{8'hE0, 8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14});

      // Abandoned break prefix must time out once and not turn the next key into a release.
      applyStimulus(8'hF0);
      abortCount = 0;
      firstAbort = -1;
      trigSeen   = 0;
      for (int i = 1; i <= TIMEOUT + 20; i++) begin
         @(negedge clk);
         if (bus.oAbort === 1'b1) begin
            abortCount++;
            if (firstAbort < 0) firstAbort = i;
         end
         if (bus.oTrig !== 1'b0) trigSeen = 1;
      end
      pend.delete();
      checkOutput("abortCount", 8'(abortCount), 8'd1);
      checkOutput("abortTiming", {7'd0, (firstAbort >= TIMEOUT && firstAbort <= TIMEOUT + 2)}, 8'd1);
      checkOutput("noEventOnAbort", {7'd0, trigSeen}, 8'd0);
      applyStimulus(8'h1C);

      applyStimulus(8'hE0);
      doReset();
      applyStimulus(8'h1C);

      for (int n = 0; n < 250; n++) begin
         op = $urandom_range(0, 6);
         k  = keyPool[$urandom_range(0, 17)];
         case (op)
            0, 1: applyStimulus(k);
            2:    applySeq('{8'hF0, k});
            3:    applySeq('{8'hE0, k});
            4:    applySeq('{8'hE0, 8'hF0, k});
            5:    applyStimulus(ignPool[$urandom_range(0, 5)]);
            default: applySeq('{8'hE0, 8'h12});
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
